// File: rtl/ofdm_rx_decode_ctrl.sv
// ofdm_rx_decode_ctrl
// Drives the OFDM decoder control inputs for one legacy 802.11a/g packet:
// decodes and checks the SIGNAL field, then re-arms the decoder for DATA
// and counts payload bytes to completion.
// Optional feature: define OFDM_RX_DECODE_CTRL_WDOG_EN to compile in a stall
// watchdog that aborts SIG_RX/DATA_RX after WDOG_CYCLES quiet cycles.

module ofdm_rx_decode_ctrl #(
    parameter int RST_CYCLES = 2
`ifdef OFDM_RX_DECODE_CTRL_WDOG_EN
    ,
    parameter logic [31:0] WDOG_CYCLES = 32'd200000
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_in_strobe,
    output logic        dec_reset,
    output logic [7:0]  dec_rate,
    output logic        dec_do_descramble,
    output logic [31:0] dec_num_bits,
    output logic        busy,
    output logic        sig_valid,
    output logic [3:0]  pkt_rate,
    output logic [11:0] pkt_len,
    output logic        pkt_byte_strobe,
    output logic        done,
    output logic        error,
    output logic [1:0]  error_code
);

    typedef enum logic [2:0] {
        IDLE, SIG_RST, SIG_RX, SIG_CHK, DATA_RST, DATA_RX
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  rst_cnt_q, rst_cnt_d;
    logic [1:0]  sig_cnt_q, sig_cnt_d;
    logic [23:0] sig_q, sig_d;
    logic [11:0] byte_cnt_q, byte_cnt_d;
    logic        dec_reset_q, dec_reset_d;
    logic [7:0]  dec_rate_q, dec_rate_d;
    logic        dec_do_descramble_q, dec_do_descramble_d;
    logic [31:0] dec_num_bits_q, dec_num_bits_d;
    logic        busy_q, busy_d;
    logic        sig_valid_q, sig_valid_d;
    logic [3:0]  pkt_rate_q, pkt_rate_d;
    logic [11:0] pkt_len_q, pkt_len_d;
    logic        pkt_byte_strobe_q, pkt_byte_strobe_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [1:0]  error_code_q, error_code_d;

    logic        parity_ok;
    logic        fields_ok;
    logic [16:0] data_bits;
    logic [11:0] byte_cnt_inc;
    logic        wdog_hit;

    // SIGNAL field checks; every legal RATE code has bit 3 set, so that bit alone validates RATE
    always_comb begin
        parity_ok    = (sig_q[17] == ^sig_q[16:0]);
        fields_ok    = sig_q[3] && !sig_q[4] && (sig_q[16:5] != 12'd0) && (sig_q[23:18] == 6'd0);
        data_bits    = 17'd44 + {1'b0, sig_q[16:5], 4'b0000};
        byte_cnt_inc = byte_cnt_q + 12'd1;
    end

    // Next-state and next-output logic; start overrides everything else
    always_comb begin
        state_d             = state_q;
        rst_cnt_d           = rst_cnt_q;
        sig_cnt_d           = sig_cnt_q;
        sig_d               = sig_q;
        byte_cnt_d          = byte_cnt_q;
        dec_reset_d         = 1'b0;
        dec_rate_d          = dec_rate_q;
        dec_do_descramble_d = dec_do_descramble_q;
        dec_num_bits_d      = dec_num_bits_q;
        sig_valid_d         = 1'b0;
        pkt_rate_d          = pkt_rate_q;
        pkt_len_d           = pkt_len_q;
        pkt_byte_strobe_d   = 1'b0;
        done_d              = 1'b0;
        error_d             = 1'b0;
        error_code_d        = error_code_q;

        if (start) begin
            state_d             = SIG_RST;
            rst_cnt_d           = 4'(RST_CYCLES - 1);
            dec_reset_d         = 1'b1;
            dec_rate_d          = 8'h0B;
            dec_do_descramble_d = 1'b0;
            dec_num_bits_d      = 32'd48;
            sig_cnt_d           = 2'd0;
            byte_cnt_d          = 12'd0;
            error_code_d        = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                SIG_RST: begin
                    if (rst_cnt_q == 4'd0) begin
                        state_d = SIG_RX;
                    end else begin
                        rst_cnt_d   = rst_cnt_q - 4'd1;
                        dec_reset_d = 1'b1;
                    end
                end
                SIG_RX: begin
                    if (byte_in_strobe) begin
                        case (sig_cnt_q)
                            2'd0:    sig_d[7:0]   = byte_in;
                            2'd1:    sig_d[15:8]  = byte_in;
                            default: sig_d[23:16] = byte_in;
                        endcase
                        if (sig_cnt_q == 2'd2) begin
                            state_d = SIG_CHK;
                        end else begin
                            sig_cnt_d = sig_cnt_q + 2'd1;
                        end
                    end else if (wdog_hit) begin
                        error_d      = 1'b1;
                        error_code_d = 2'd3;
                        state_d      = IDLE;
                    end
                end
                SIG_CHK: begin
                    if (!parity_ok) begin
                        error_d      = 1'b1;
                        error_code_d = 2'd1;
                        state_d      = IDLE;
                    end else if (!fields_ok) begin
                        error_d      = 1'b1;
                        error_code_d = 2'd2;
                        state_d      = IDLE;
                    end else begin
                        sig_valid_d         = 1'b1;
                        pkt_rate_d          = sig_q[3:0];
                        pkt_len_d           = sig_q[16:5];
                        dec_rate_d          = {4'b0000, sig_q[3:0]};
                        dec_do_descramble_d = 1'b1;
                        dec_num_bits_d      = {15'd0, data_bits};
                        rst_cnt_d           = 4'(RST_CYCLES);
                        state_d             = DATA_RST;
                    end
                end
                DATA_RST: begin
                    if (rst_cnt_q == 4'd0) begin
                        state_d = DATA_RX;
                    end else begin
                        rst_cnt_d   = rst_cnt_q - 4'd1;
                        dec_reset_d = 1'b1;
                    end
                end
                DATA_RX: begin
                    if (byte_in_strobe) begin
                        pkt_byte_strobe_d = 1'b1;
                        byte_cnt_d        = byte_cnt_inc;
                        if (byte_cnt_inc == pkt_len_q) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (wdog_hit) begin
                        error_d      = 1'b1;
                        error_code_d = 2'd3;
                        state_d      = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

`ifdef OFDM_RX_DECODE_CTRL_WDOG_EN
    logic [31:0] wdog_q, wdog_d;

    // Fires so that the abort lands exactly WDOG_CYCLES cycles after the last activity
    assign wdog_hit = ((state_q == SIG_RX) || (state_q == DATA_RX)) && !byte_in_strobe &&
                      (wdog_q == WDOG_CYCLES - 32'd2);

    // Quiet-cycle counter, restarted by any state change or received byte
    always_comb begin
        if ((state_q == IDLE) || (state_d != state_q) || byte_in_strobe) begin
            wdog_d = 32'd0;
        end else begin
            wdog_d = wdog_q + 32'd1;
        end
    end

    // Watchdog counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            wdog_q <= 32'd0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign wdog_hit = 1'b0;
`endif

    // State and output registers; decoder is held in reset while we are
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q             <= IDLE;
            rst_cnt_q           <= 4'd0;
            sig_cnt_q           <= 2'd0;
            sig_q               <= 24'd0;
            byte_cnt_q          <= 12'd0;
            dec_reset_q         <= 1'b1;
            dec_rate_q          <= 8'h0B;
            dec_do_descramble_q <= 1'b0;
            dec_num_bits_q      <= 32'd48;
            busy_q              <= 1'b0;
            sig_valid_q         <= 1'b0;
            pkt_rate_q          <= 4'd0;
            pkt_len_q           <= 12'd0;
            pkt_byte_strobe_q   <= 1'b0;
            done_q              <= 1'b0;
            error_q             <= 1'b0;
            error_code_q        <= 2'd0;
        end else begin
            state_q             <= state_d;
            rst_cnt_q           <= rst_cnt_d;
            sig_cnt_q           <= sig_cnt_d;
            sig_q               <= sig_d;
            byte_cnt_q          <= byte_cnt_d;
            dec_reset_q         <= dec_reset_d;
            dec_rate_q          <= dec_rate_d;
            dec_do_descramble_q <= dec_do_descramble_d;
            dec_num_bits_q      <= dec_num_bits_d;
            busy_q              <= busy_d;
            sig_valid_q         <= sig_valid_d;
            pkt_rate_q          <= pkt_rate_d;
            pkt_len_q           <= pkt_len_d;
            pkt_byte_strobe_q   <= pkt_byte_strobe_d;
            done_q              <= done_d;
            error_q             <= error_d;
            error_code_q        <= error_code_d;
        end
    end

    assign dec_reset         = dec_reset_q;
    assign dec_rate          = dec_rate_q;
    assign dec_do_descramble = dec_do_descramble_q;
    assign dec_num_bits      = dec_num_bits_q;
    assign busy              = busy_q;
    assign sig_valid         = sig_valid_q;
    assign pkt_rate          = pkt_rate_q;
    assign pkt_len           = pkt_len_q;
    assign pkt_byte_strobe   = pkt_byte_strobe_q;
    assign done              = done_q;
    assign error             = error_q;
    assign error_code        = error_code_q;

endmodule

// File: tb/tb_ofdm_rx_decode_ctrl.sv
// tb_ofdm_rx_decode_ctrl
// Self-checking bench for ofdm_rx_decode_ctrl. SIGNAL words are built and
// judged by a field-level model (parity by bit counting, RATE by table
// lookup); pulse outputs are tallied by a negedge monitor.
// Watchdog scenario is selected by OFDM_RX_DECODE_CTRL_WDOG_EN.

module tb_ofdm_rx_decode_ctrl;

    localparam int RST = 3;
`ifdef OFDM_RX_DECODE_CTRL_WDOG_EN
    localparam logic [31:0] WDOG = 32'd1000;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_in_strobe;
    logic        dec_reset;
    logic [7:0]  dec_rate;
    logic        dec_do_descramble;
    logic [31:0] dec_num_bits;
    logic        busy;
    logic        sig_valid;
    logic [3:0]  pkt_rate;
    logic [11:0] pkt_len;
    logic        pkt_byte_strobe;
    logic        done;
    logic        error;
    logic [1:0]  error_code;

    int n_checks = 0;
    int n_errors = 0;
    int n_pbs    = 0;
    int n_done   = 0;
    int n_err    = 0;
    int n_sv     = 0;

    localparam logic [64:0] RESET_VEC = {1'b1, 8'h0B, 1'b0, 32'd48, 1'b0, 1'b0, 4'h0, 12'h000,
                                         1'b0, 1'b0, 1'b0, 2'b00};

    always #5 clock = ~clock;

    ofdm_rx_decode_ctrl #(
        .RST_CYCLES(RST)
`ifdef OFDM_RX_DECODE_CTRL_WDOG_EN
        , .WDOG_CYCLES(WDOG)
`endif
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .byte_in(byte_in),
        .byte_in_strobe(byte_in_strobe),
        .dec_reset(dec_reset),
        .dec_rate(dec_rate),
        .dec_do_descramble(dec_do_descramble),
        .dec_num_bits(dec_num_bits),
        .busy(busy),
        .sig_valid(sig_valid),
        .pkt_rate(pkt_rate),
        .pkt_len(pkt_len),
        .pkt_byte_strobe(pkt_byte_strobe),
        .done(done),
        .error(error),
        .error_code(error_code)
    );

    // Tally pulse outputs mid-cycle
    always @(negedge clock) begin
        if (pkt_byte_strobe === 1'b1) n_pbs++;
        if (done === 1'b1) n_done++;
        if (error === 1'b1) n_err++;
        if (sig_valid === 1'b1) n_sv++;
    end

    // Hard time limit so the run always terminates
    initial begin
        #500000;
        $display("[TB] FAIL timeout: time budget exhausted, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [64:0] out_vec();
        return {dec_reset, dec_rate, dec_do_descramble, dec_num_bits, busy, sig_valid, pkt_rate,
                pkt_len, pkt_byte_strobe, done, error, error_code};
    endfunction

    // Build a SIGNAL word from its fields with correct even parity in bit 17
    function automatic logic [23:0] make_signal(input int rate, input int len, input int rsvd, input int tail);
        int low;
        int ones;
        low  = (rate % 16) + (rsvd % 2) * 16 + (len % 4096) * 32;
        ones = 0;
        for (int i = 0; i < 17; i++) ones += (low >> i) % 2;
        return 24'(low + (ones % 2) * (1 << 17) + (tail % 64) * (1 << 18));
    endfunction

    // Expected verdict: 0 = pass, 1 = parity, 2 = bad RATE/reserved/length/tail
    function automatic int model_code(input logic [23:0] w);
        int ones;
        int rate;
        int len;
        bit rate_ok;
        int legal_rates [8];
        legal_rates = '{11, 15, 10, 14, 9, 13, 8, 12};
        ones = 0;
        for (int i = 0; i < 17; i++) ones += int'(w[i]);
        if ((ones % 2) != int'(w[17])) return 1;
        rate    = int'(w[3:0]);
        len     = int'(w[16:5]);
        rate_ok = 1'b0;
        foreach (legal_rates[i]) if (legal_rates[i] == rate) rate_ok = 1'b1;
        if (!rate_ok || (w[4] != 1'b0) || (len == 0) || (w[23:18] != 6'd0)) return 2;
        return 0;
    endfunction

    // Start a packet, feed SIGNAL, then up to data_bytes payload bytes
    task automatic run_packet(input logic [23:0] w, input int data_bytes);
        int code;
        int len;
        int highs;
        int pbs0, done0, err0, sv0;
        int gap;
        int n_send;
        logic [31:0] exp_bits;
        code     = model_code(w);
        len      = int'(w[16:5]);
        exp_bits = 32'(44 + 16 * len);
        pbs0 = n_pbs; done0 = n_done; err0 = n_err; sv0 = n_sv;

        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (dec_reset !== 1'b1) begin n_errors++; $display("[TB] FAIL start_dec_reset: got %0b expected 1", dec_reset); end
        n_checks++; if ({dec_rate, dec_do_descramble, dec_num_bits} !== {8'h0B, 1'b0, 32'd48}) begin n_errors++; $display("[TB] FAIL start_config: got %h/%0b/%0d expected 0b/0/48", dec_rate, dec_do_descramble, dec_num_bits); end
        n_checks++; if ({busy, error_code} !== {1'b1, 2'd0}) begin n_errors++; $display("[TB] FAIL start_busy_code: got busy=%0b code=%0d expected 1/0", busy, error_code); end

        highs = 1;
        for (int k = 1; k <= RST; k++) begin
            byte_in = 8'($urandom);
            byte_in_strobe = 1'b1;
            tick();
            if (dec_reset === 1'b1) highs++;
        end
        byte_in_strobe = 1'b0;
        n_checks++; if (highs != RST) begin n_errors++; $display("[TB] FAIL sig_reset_width: got %0d cycles expected %0d", highs, RST); end

        for (int i = 0; i < 3; i++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) tick();
            byte_in = w[8*i +: 8];
            byte_in_strobe = 1'b1;
            tick();
            byte_in_strobe = 1'b0;
        end
        n_checks++; if ({sig_valid, error} !== 2'b00) begin n_errors++; $display("[TB] FAIL sig_early: got sv=%0b err=%0b expected 0/0", sig_valid, error); end
        tick();
        n_checks++; if ({sig_valid, error} !== {1'(code == 0), 1'(code != 0)}) begin n_errors++; $display("[TB] FAIL sig_verdict w=%h: got sv=%0b err=%0b expected code %0d", w, sig_valid, error, code); end
        n_checks++; if (error_code !== 2'(code)) begin n_errors++; $display("[TB] FAIL error_code w=%h: got %0d expected %0d", w, error_code, code); end
        if (code == 0) begin
            n_checks++; if ({dec_rate, dec_do_descramble, dec_num_bits} !== {4'h0, w[3:0], 1'b1, exp_bits}) begin n_errors++; $display("[TB] FAIL data_config: got %h/%0b/%0d expected %h/1/%0d", dec_rate, dec_do_descramble, dec_num_bits, w[3:0], exp_bits); end
            n_checks++; if ({pkt_rate, pkt_len} !== {w[3:0], w[16:5]}) begin n_errors++; $display("[TB] FAIL pkt_fields: got %h/%0d expected %h/%0d", pkt_rate, pkt_len, w[3:0], w[16:5]); end
        end else begin
            n_checks++; if ({busy, dec_rate, dec_do_descramble, dec_num_bits} !== {1'b0, 8'h0B, 1'b0, 32'd48}) begin n_errors++; $display("[TB] FAIL abort_state: got busy=%0b cfg=%h/%0b/%0d expected 0 0b/0/48", busy, dec_rate, dec_do_descramble, dec_num_bits); end
        end

        highs = 0;
        for (int k = 1; k <= RST + 1; k++) begin
            byte_in = 8'($urandom);
            byte_in_strobe = 1'b1;
            tick();
            if (dec_reset === 1'b1) highs++;
        end
        byte_in_strobe = 1'b0;
        n_checks++; if (highs != ((code == 0) ? RST : 0)) begin n_errors++; $display("[TB] FAIL data_reset_width: got %0d cycles expected %0d", highs, (code == 0) ? RST : 0); end

        if (code != 0) begin
            tick();
            n_checks++; if ((n_err - err0) != 1 || n_sv != sv0 || n_done != done0) begin n_errors++; $display("[TB] FAIL abort_pulses: got err=%0d sv=%0d done=%0d expected 1/0/0", n_err - err0, n_sv - sv0, n_done - done0); end
            n_checks++; if ({busy, error_code} !== {1'b0, 2'(code)}) begin n_errors++; $display("[TB] FAIL abort_hold: got busy=%0b code=%0d expected 0/%0d", busy, error_code, code); end
            return;
        end

        n_send = (data_bytes < len) ? data_bytes : len;
        for (int b = 0; b < n_send; b++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) tick();
            byte_in = 8'($urandom);
            byte_in_strobe = 1'b1;
            tick();
            byte_in_strobe = 1'b0;
            n_checks++; if ({pkt_byte_strobe, done} !== {1'b1, 1'(b == len - 1)}) begin n_errors++; $display("[TB] FAIL byte_%0d: got pbs=%0b done=%0b expected 1/%0b", b + 1, pkt_byte_strobe, done, b == len - 1); end
        end
        tick();
        if (n_send == len) begin
            n_checks++; if ({done, busy} !== 2'b00) begin n_errors++; $display("[TB] FAIL after_done: got done=%0b busy=%0b expected 0/0", done, busy); end
            n_checks++; if ((n_pbs - pbs0) != len || (n_done - done0) != 1 || n_err != err0 || (n_sv - sv0) != 1) begin n_errors++; $display("[TB] FAIL packet_counts: got pbs=%0d done=%0d err=%0d sv=%0d expected %0d/1/0/1", n_pbs - pbs0, n_done - done0, n_err - err0, n_sv - sv0, len); end
        end else begin
            n_checks++; if (busy !== 1'b1 || n_done != done0 || (n_pbs - pbs0) != n_send) begin n_errors++; $display("[TB] FAIL partial_packet: got busy=%0b done=%0d pbs=%0d expected 1/0/%0d", busy, n_done - done0, n_pbs - pbs0, n_send); end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (out_vec() !== RESET_VEC) begin n_errors++; $display("[TB] FAIL reset_outputs: got %h expected %h", out_vec(), RESET_VEC); end
        reset = 1'b0;
        tick();
        n_checks++; if ({dec_reset, busy} !== 2'b00) begin n_errors++; $display("[TB] FAIL reset_release: got dec_reset=%0b busy=%0b expected 0/0", dec_reset, busy); end
    endtask

    task automatic test_valid_packet();
        run_packet(make_signal(13, 100, 0, 0), 1000);
    endtask

    task automatic test_random_packets();
        int legal_rates [8];
        legal_rates = '{11, 15, 10, 14, 9, 13, 8, 12};
        for (int n = 0; n < 6; n++) begin
            run_packet(make_signal(legal_rates[$urandom_range(0, 7)], int'($urandom_range(1, 40)), 0, 0), 1000);
        end
    endtask

    task automatic test_parity_error();
        run_packet(make_signal(11, 20, 0, 0) ^ 24'h020000, 0);
        run_packet(make_signal(12, int'($urandom_range(1, 4095)), 0, 0) ^ 24'h020000, 0);
    endtask

    task automatic test_bad_fields();
        run_packet(make_signal(3, 50, 0, 0), 0);
        run_packet(make_signal(13, 0, 0, 0), 0);
        run_packet(make_signal(0, 7, 0, 0), 0);
        run_packet(make_signal(9, 7, 1, 0), 0);
        run_packet(make_signal(9, 7, 0, 21), 0);
        run_packet(make_signal(3, 50, 0, 0) ^ 24'h020000, 0);
    endtask

    task automatic test_random_words();
        logic [23:0] w;
        for (int n = 0; n < 8; n++) begin
            w = 24'($urandom);
            w[16:5] = 12'($urandom_range(0, 63));
            run_packet(w, 1000);
        end
    endtask

    task automatic test_back_to_back();
        run_packet(make_signal(8, 1, 0, 0), 1000);
        run_packet(make_signal(15, 4095 & 3, 0, 0), 1000);
    endtask

    task automatic test_restart_mid_data();
        int pbs0, done0, err0;
        pbs0 = n_pbs; done0 = n_done; err0 = n_err;
        run_packet(make_signal(13, 30, 0, 0), 10);
        run_packet(make_signal(11, 5, 0, 0), 1000);
        n_checks++; if ((n_done - done0) != 1 || n_err != err0 || (n_pbs - pbs0) != 15) begin n_errors++; $display("[TB] FAIL restart_counts: got done=%0d err=%0d pbs=%0d expected 1/0/15", n_done - done0, n_err - err0, n_pbs - pbs0); end
    endtask

    task automatic test_watchdog();
        int waited;
        int err0;
        err0 = n_err;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < RST; k++) tick();
        for (int i = 0; i < 2; i++) begin
            byte_in = 8'($urandom);
            byte_in_strobe = 1'b1;
            tick();
            byte_in_strobe = 1'b0;
        end
`ifdef OFDM_RX_DECODE_CTRL_WDOG_EN
        waited = 0;
        while (error !== 1'b1 && waited < 1100) begin
            tick();
            waited++;
        end
        n_checks++; if (waited != int'(WDOG) - 1) begin n_errors++; $display("[TB] FAIL wdog_latency: got %0d cycles after strobe expected %0d", waited + 1, WDOG); end
        n_checks++; if (error_code !== 2'd3) begin n_errors++; $display("[TB] FAIL wdog_code: got %0d expected 3", error_code); end
        tick();
        n_checks++; if (busy !== 1'b0 || (n_err - err0) != 1) begin n_errors++; $display("[TB] FAIL wdog_idle: got busy=%0b err=%0d expected 0/1", busy, n_err - err0); end
`else
        waited = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            waited++;
        end
        n_checks++; if ({busy, error_code} !== {1'b1, 2'd0} || n_err != err0) begin n_errors++; $display("[TB] FAIL stall_wait after %0d: got busy=%0b code=%0d err=%0d expected 1/0/0", waited, busy, error_code, n_err - err0); end
`endif
        run_packet(make_signal(10, 6, 0, 0), 1000);
    endtask

    task automatic test_reset_mid_data();
        int pbs0, done0;
        run_packet(make_signal(15, 20, 0, 0), 5);
        pbs0 = n_pbs; done0 = n_done;
        reset = 1'b1;
        byte_in = 8'($urandom);
        byte_in_strobe = 1'b1;
        tick();
        n_checks++; if (out_vec() !== RESET_VEC) begin n_errors++; $display("[TB] FAIL reset_mid_outputs: got %h expected %h", out_vec(), RESET_VEC); end
        tick();
        reset = 1'b0;
        tick();
        n_checks++; if ({dec_reset, busy, pkt_byte_strobe} !== 3'b000) begin n_errors++; $display("[TB] FAIL reset_mid_release: got dec_reset=%0b busy=%0b pbs=%0b expected 0/0/0", dec_reset, busy, pkt_byte_strobe); end
        for (int k = 0; k < 5; k++) begin
            byte_in = 8'($urandom);
            tick();
        end
        byte_in_strobe = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0 || n_pbs != pbs0 || n_done != done0) begin n_errors++; $display("[TB] FAIL stray_strobes: got busy=%0b pbs=%0d done=%0d expected 0/0/0", busy, n_pbs - pbs0, n_done - done0); end
        run_packet(make_signal(14, 3, 0, 0), 1000);
    endtask

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        byte_in        = 8'h00;
        byte_in_strobe = 1'b0;
        test_reset();
        test_valid_packet();
        test_random_packets();
        test_parity_error();
        test_bad_fields();
        test_random_words();
        test_back_to_back();
        test_restart_mid_data();
        test_watchdog();
        test_reset_mid_data();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ofdm_rx_decode_ctrl.md
# ofdm_rx_decode_ctrl

Sequencer that drives the OFDM decoder's control inputs for one 802.11a/g legacy packet. It starts the decoder on the SIGNAL field (6 Mb/s, no descramble, 24 bits), collects and checks the three SIGNAL bytes, then reprograms and re-arms the decoder for the DATA field. It counts DATA payload bytes to completion. It sits between the packet-detect/sync logic (which issues `start`) and the decoder instance, whose `rate`, `do_descramble`, `num_bits_to_decode` and `reset` it owns.

## Interface
Parameters:
- `RST_CYCLES`, 2: width in cycles of each `dec_reset` pulse (1..15).
- `WDOG_CYCLES`, 32'd200000: watchdog limit in cycles (only with the watchdog compiled in).

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse: SIGNAL symbol about to enter the decoder.
- `byte_in`  in  8  decoder byte output.
- `byte_in_strobe`  in  1  decoder byte valid.
- `dec_reset`  out  1  reset to decoder (OR'd externally with global reset).
- `dec_rate`  out  8  decoder `rate`; `{4'b0, RATE}`.
- `dec_do_descramble`  out  1  decoder `do_descramble`.
- `dec_num_bits`  out  32  decoder `num_bits_to_decode`.
- `busy`  out  1  high in every state except IDLE.
- `sig_valid`  out  1  one-cycle pulse: SIGNAL passed checks.
- `pkt_rate`  out  4  RATE field; valid from `sig_valid` until next `start`.
- `pkt_len`  out  12  LENGTH field; same validity.
- `pkt_byte_strobe`  out  1  copy of `byte_in_strobe` during DATA_RX payload bytes only.
- `done`  out  1  one-cycle pulse: LENGTH payload bytes received.
- `error`  out  1  one-cycle pulse on any abort.
- `error_code`  out  2  1 = parity, 2 = bad RATE/reserved/tail, 3 = watchdog; holds until next `start`.

## Operation
- States: IDLE, SIG_RST, SIG_RX, SIG_CHK, DATA_RST, DATA_RX.
- IDLE: on `start` -> SIG_RST. Load `dec_rate`=8'h0B, `dec_do_descramble`=0, `dec_num_bits`=48. Clear byte counter and `error_code`.
- SIG_RST: `dec_reset`=1 for `RST_CYCLES` cycles -> SIG_RX.
- SIG_RX: capture bytes b0,b1,b2 on `byte_in_strobe`. The third byte -> SIG_CHK.
- SIG_CHK (1 cycle) checks the received bits, with bit n = b[n/8][n%8]:
  - RATE = bits[3:0]. Must be one of 0xB,0xF,0xA,0xE,0x9,0xD,0x8,0xC.
  - bit4 (reserved) must be 0.
  - LENGTH = bits[16:5]. Must be non-zero.
  - bit17 must equal XOR of bits[16:0]. On mismatch: code 1. This check has priority over code 2.
  - bits[23:18] must be 0.
  - Pass: pulse `sig_valid`, latch `pkt_rate`/`pkt_len`, and program `dec_rate`={4'b0,RATE}, `dec_do_descramble`=1, `dec_num_bits`=44+16*LENGTH (zero-extended, computed in 17 bits). Then -> DATA_RST.
  - Fail: pulse `error` -> IDLE.
- DATA_RST: `dec_reset` for `RST_CYCLES` cycles -> DATA_RX.
- DATA_RX: count bytes. Byte k (k = 1..LENGTH) is forwarded via `pkt_byte_strobe`. On the LENGTH-th byte, pulse `done` -> IDLE.
- After a packet (`done` or `error`), the `dec_*` configuration outputs hold their values.
- `start` while busy: abort, no `error` pulse, restart at SIG_RST in the next cycle. `start` wins over all other events in the same cycle.
- `byte_in_strobe` is ignored in IDLE, SIG_RST, DATA_RST, SIG_CHK.

## Timing
- Reset values:
  - `dec_reset`=1 while `reset`, 0 on the cycle after.
  - `dec_rate`=8'h0B, `dec_do_descramble`=0, `dec_num_bits`=48.
  - All flags 0; `pkt_rate`, `pkt_len`, `error_code` = 0.
- All outputs are registered.
- `start` at cycle t: `dec_reset` is high for cycles t+1..t+RST_CYCLES, and `dec_rate` is valid from t+1.
- Third SIGNAL byte strobe at cycle t: `sig_valid`/`error` and the new `dec_*` values appear at t+2; `dec_reset` (DATA) starts at t+3.
- `done` is asserted in the cycle after the last-byte strobe.
- `pkt_byte_strobe` is 1 cycle behind `byte_in_strobe`.

## Configuration
- `OFDM_RX_DECODE_CTRL_WDOG_EN` defined:
  - A 32-bit counter clears on every state change and every `byte_in_strobe`, and increments otherwise while busy.
  - Reaching `WDOG_CYCLES` in SIG_RX or DATA_RX pulses `error`, sets code 3, and returns to IDLE.
- Undefined: no counter; the block waits indefinitely; code 3 is never produced.

## Test plan
- Valid SIGNAL, RATE=0xD (36M), LENGTH=100 (parity correct) -> `sig_valid`, `dec_rate`=8'h0D, `dec_num_bits`=1644, `dec_do_descramble`=1. After 100 bytes, `done` occurs 1 cycle after the 100th strobe, with exactly 100 `pkt_byte_strobe`s.
- SIGNAL with the parity bit flipped -> `error`, `error_code`=1, no DATA `dec_reset`, back to IDLE.
- RATE=0x3 with correct parity -> `error_code`=2. LENGTH=0 -> `error_code`=2.
- `start` reasserted mid-DATA_RX after 10 bytes -> no `done`/`error`. `dec_reset` for RST_CYCLES, config back to 0B/0/48, and the next valid packet completes normally.
- With `OFDM_RX_DECODE_CTRL_WDOG_EN` and `WDOG_CYCLES`=1000, stall after 2 SIGNAL bytes -> `error`, `error_code`=3 exactly 1000 cycles after the last strobe.
- `reset` asserted during DATA_RX -> next cycle all outputs at reset values, state IDLE, stray `byte_in_strobe`s ignored.
